// File: rtl/key_pkg.sv
// Shared definitions for pushbutton conditioning: press-state encoding and default timing.
package key_pkg;

    localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Debounced level currently accepted in a given state (1 = key held).
    function automatic logic accepted_level(input key_state_t s);
        return (s == HELD) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is configurable so
// the idle level of the source is presented while in reset.
module sync_2ff #(
    parameter bit RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronizer, counter debounce, press FSM, press strobe and toggle.
// Optional long-hold strobe is built when LONG_PRESS_EN is defined.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter bit          TOGGLE_INIT     = 1'b0,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_async,
    input  logic clear,
    output logic pressed,
    output logic press_pulse,
    output logic toggle,
    output logic long_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("key_conditioner: requires DEBOUNCE_CYCLES >= 1 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic             key_sync;
    logic             raw_p;
    key_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pressed_next;
    logic             press_pulse_next;
    logic             toggle_next;
    logic             deb_done;
    logic             enter_held;

    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_async),
        .q     (key_sync)
    );

    assign raw_p = key_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pressed     <= 1'b0;
            press_pulse <= 1'b0;
            toggle      <= TOGGLE_INIT;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pressed     <= pressed_next;
            press_pulse <= press_pulse_next;
            toggle      <= toggle_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        pressed_next     = pressed;
        press_pulse_next = 1'b0;
        toggle_next      = toggle;
        enter_held       = 1'b0;
        deb_done         = (cnt == CNT_W'(DEBOUNCE_CYCLES));

        case (state)
            IDLE: begin
                if (raw_p) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!raw_p) begin
                    state_next = IDLE;
                end else if (deb_done) begin
                    state_next       = HELD;
                    enter_held       = 1'b1;
                    pressed_next     = 1'b1;
                    press_pulse_next = 1'b1;
                    toggle_next      = ~toggle;
                end
            end
            HELD: begin
                if (!raw_p) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (raw_p) begin
                    state_next = HELD;
                end else if (deb_done) begin
                    state_next   = IDLE;
                    pressed_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Count disagreeing samples; settling into a stable state restarts the count.
        if (raw_p == accepted_level(state)) begin
            cnt_next = '0;
        end else if (state_next != state && (state == PRESS_WAIT || state == RELEASE_WAIT)) begin
            cnt_next = '0;
        end else if (!deb_done) begin
            cnt_next = cnt + CNT_W'(1);
        end

        if (clear) toggle_next = TOGGLE_INIT;
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic              long_pulse_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            hold_cnt   <= hold_cnt_next;
            long_pulse <= long_pulse_next;
        end
    end

    // Hold timer saturates at LONG_CYCLES so each press yields at most one strobe.
    always_comb begin
        hold_cnt_next   = hold_cnt;
        long_pulse_next = 1'b0;
        if (enter_held || state == IDLE) begin
            hold_cnt_next = '0;
        end else if ((state == HELD || state == RELEASE_WAIT) &&
                     hold_cnt != HOLD_W'(LONG_CYCLES)) begin
            hold_cnt_next   = hold_cnt + HOLD_W'(1);
            long_pulse_next = (hold_cnt_next == HOLD_W'(LONG_CYCLES));
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low key),
// plus a DEBOUNCE_CYCLES=1 instance for the minimum-debounce case.
module tb_key_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic clk = 1'b0;
    logic reset;
    logic key_async;
    logic clear;
    logic pressed, press_pulse, toggle, long_pulse;

    logic key1;
    logic clear1;
    logic pressed1, press_pulse1, toggle1, long_pulse1;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses, longs, falls, first_long;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1'b1),
        .TOGGLE_INIT     (1'b0),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_async   (key_async),
        .clear       (clear),
        .pressed     (pressed),
        .press_pulse (press_pulse),
        .toggle      (toggle),
        .long_pulse  (long_pulse)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1'b1),
        .TOGGLE_INIT     (1'b0),
        .LONG_CYCLES     (LONG)
    ) dut_min (
        .clk         (clk),
        .reset       (reset),
        .key_async   (key1),
        .clear       (clear1),
        .pressed     (pressed1),
        .press_pulse (press_pulse1),
        .toggle      (toggle1),
        .long_pulse  (long_pulse1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        pulses = 0;
        longs  = 0;
        falls  = 0;
    endtask

    // Advance n cycles, tallying strobes and falling edges of pressed.
    task automatic run(input int n);
        logic prev;
        for (int i = 0; i < n; i++) begin
            prev = pressed;
            tick();
            if (press_pulse) pulses++;
            if (long_pulse) longs++;
            if (prev && !pressed) falls++;
        end
    endtask

    // Key already asserted: strobe must appear exactly on the 7th edge (2 sync + 4 + 1).
    task automatic expect_press(input string tag, input logic exp_toggle);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check({tag, "_pulse"}, 32'(press_pulse), (i == 7) ? 32'd1 : 32'd0);
        end
        check({tag, "_pressed"}, 32'(pressed), 32'd1);
        check({tag, "_toggle"}, 32'(toggle), 32'(exp_toggle));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_async = 1'b1; clear = 1'b0; key1 = 1'b1; clear1 = 1'b0;
        repeat (3) tick();
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_pulse", 32'(press_pulse), 32'd0);
        check("rst_toggle", 32'(toggle), 32'd0);
        check("rst_long", 32'(long_pulse), 32'd0);
        reset = 1'b0;
        clr_counts(); run(5);
        check("idle_pulses", 32'(pulses), 32'd0);

        // Clean press and release.
        key_async = 1'b0;
        expect_press("t1", 1'b1);
        tick();
        check("t1_pulse_one_cycle", 32'(press_pulse), 32'd0);
        clr_counts(); run(5);
        key_async = 1'b1; run(10);
        check("t1_hold_pulses", 32'(pulses), 32'd0);
        check("t1_falls", 32'(falls), 32'd1);
        check("t1_released", 32'(pressed), 32'd0);

        // Bounce shorter than the debounce window is rejected.
        clr_counts();
        key_async = 1'b0; run(2);
        key_async = 1'b1; run(2);
        key_async = 1'b0; run(2);
        key_async = 1'b1; run(10);
        check("t2_pulses", 32'(pulses), 32'd0);
        check("t2_pressed", 32'(pressed), 32'd0);
        check("t2_toggle", 32'(toggle), 32'd1);

        // Release with a 2-cycle glitch back to pressed.
        key_async = 1'b0;
        expect_press("t3a", 1'b0);
        clr_counts();
        key_async = 1'b1; run(3);
        key_async = 1'b0; run(2);
        check("t3_glitch_pressed", 32'(pressed), 32'd1);
        key_async = 1'b1; run(20);
        check("t3_pulses", 32'(pulses), 32'd0);
        check("t3_falls", 32'(falls), 32'd1);
        check("t3_released", 32'(pressed), 32'd0);
        key_async = 1'b0;
        expect_press("t3c", 1'b1);
        key_async = 1'b1; run(10);

        // Clear alone, then clear coinciding with an accepted press.
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_toggle", 32'(toggle), 32'd0);
        clr_counts();
        key_async = 1'b0; run(6);
        check("t4_early_pulses", 32'(pulses), 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t4_pulse", 32'(press_pulse), 32'd1);
        check("t4_toggle", 32'(toggle), 32'd0);
        check("t4_pressed", 32'(pressed), 32'd1);
        tick();
        check("t4_pulse_end", 32'(press_pulse), 32'd0);
        key_async = 1'b1; run(10);

        // Asynchronous reset mid-hold, key still held afterwards.
        key_async = 1'b0;
        expect_press("t5a", 1'b1);
        run(2);
        #2 reset = 1'b1;
        #1;
        check("t5_async_pressed", 32'(pressed), 32'd0);
        check("t5_async_toggle", 32'(toggle), 32'd0);
        tick(); tick();
        reset = 1'b0;
        expect_press("t5b", 1'b1);
        key_async = 1'b1; run(10);

        // Reset in PRESS_WAIT with count at 3.
        key_async = 1'b0; run(5);
        check("t5_pw_pressed", 32'(pressed), 32'd0);
        reset = 1'b1;
        #1;
        check("t5_pw_toggle", 32'(toggle), 32'd0);
        tick(); tick();
        reset = 1'b0;
        expect_press("t5d", 1'b1);
        key_async = 1'b1; run(10);

        // Long hold.
        key_async = 1'b0;
        expect_press("t6", 1'b0);
        longs = 0; first_long = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (long_pulse) begin
                longs++;
                if (first_long == 0) first_long = i;
            end
        end
        check("t6_still_pressed", 32'(pressed), 32'd1);
`ifdef LONG_PRESS_EN
        check("t6_long_count", 32'(longs), 32'd1);
        check("t6_long_delay", 32'(first_long), 32'(LONG));
`else
        check("t6_long_count", 32'(longs), 32'd0);
`endif
        key_async = 1'b1; run(10);

        // Minimum debounce of one sample: press at 4th edge, release at 4th edge.
        key1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("min_pulse", 32'(press_pulse1), (i == 4) ? 32'd1 : 32'd0);
        end
        check("min_toggle", 32'(toggle1), 32'd1);
        key1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("min_pressed", 32'(pressed1), (i == 4) ? 32'd0 : 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
